// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential square-root unit: FSM encoding and
// the root-width derivation from the operand width.
package sqrt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic int unsigned res_w(input int unsigned width);
    return (width + 1) / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: brings in two operand
// bits, trial-subtracts {root, 01} and shifts the resulting root bit in.
module sqrt_step #(
  parameter int unsigned RES_W = 11
) (
  input  logic [RES_W+1:0] rem_i,
  input  logic [RES_W-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [RES_W+1:0] rem_o,
  output logic [RES_W-1:0] root_o
);

  logic [RES_W+3:0] shifted;
  logic [RES_W+1:0] trial;
  logic             ge;

  always_comb begin
    shifted = {rem_i, bits_i};
    trial   = {root_i, 2'b01};
    // Bits above the trial width can only be set when the remainder exceeds it.
    ge      = (|shifted[RES_W+3:RES_W+2]) | (shifted[RES_W+1:0] >= trial);
    rem_o   = ge ? (shifted[RES_W+1:0] - trial) : shifted[RES_W+1:0];
    root_o  = RES_W'({root_i, ge});
  end

endmodule

// File: rtl/sqrt_seq.sv
// Sequential integer square root, one root bit per clock, valid/ready on both
// sides. Define SQRT_SEQ_ROUND_EN to round the root to nearest (saturating).
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 21,
  localparam int unsigned RES_W = res_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] root,
  output logic [RES_W:0]   rem,
  output logic             busy
);

  localparam int unsigned CNT_W = (RES_W > 1) ? $clog2(RES_W) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*RES_W-1:0]   opnd_q, opnd_d;
  logic [RES_W+1:0]     wrem_q, wrem_d;
  logic [RES_W-1:0]     wroot_q, wroot_d;
  logic [RES_W-1:0]     root_q, root_d;
  logic [RES_W:0]       rem_q, rem_d;

  logic [RES_W+1:0]     step_rem;
  logic [RES_W-1:0]     step_root;
  logic [RES_W-1:0]     root_fin;

  sqrt_step #(
    .RES_W(RES_W)
  ) u_step (
    .rem_i (wrem_q),
    .root_i(wroot_q),
    .bits_i(opnd_q[2*RES_W-1 -: 2]),
    .rem_o (step_rem),
    .root_o(step_root)
  );

`ifdef SQRT_SEQ_ROUND_EN
  logic [RES_W:0] root_inc;

  always_comb begin
    root_inc = {1'b0, step_root} + 1'b1;
    root_fin = step_root;
    if (step_rem > {2'b00, step_root}) begin
      root_fin = root_inc[RES_W] ? '1 : root_inc[RES_W-1:0];
    end
  end
`else
  assign root_fin = step_root;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    wrem_d  = wrem_q;
    wroot_d = wroot_q;
    root_d  = root_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          opnd_d             = '0;
          opnd_d[WIDTH-1:0]  = x;
          wrem_d             = '0;
          wroot_d            = '0;
          cnt_d              = CNT_W'(RES_W - 1);
          state_d            = StBusy;
        end
      end
      StBusy: begin
        opnd_d  = opnd_q << 2;
        wrem_d  = step_rem;
        wroot_d = step_root;
        if (cnt_q == '0) begin
          root_d  = root_fin;
          // Final remainder is at most 2*root, so the top working bit is zero.
          rem_d   = step_rem[RES_W:0];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opnd_q  <= '0;
      wrem_q  <= '0;
      wroot_q <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      wrem_q  <= wrem_d;
      wroot_q <= wroot_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StBusy);
  assign root      = root_q;
  assign rem       = rem_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// Directed bench for sqrt_seq: a WIDTH=21 instance for the main checks and a
// WIDTH=8 instance for root saturation. Honours SQRT_SEQ_ROUND_EN.
module tb_sqrt_seq;

`ifdef SQRT_SEQ_ROUND_EN
  localparam int unsigned R21 = 5;
`else
  localparam int unsigned R21 = 4;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [20:0] x;
  logic [10:0] root;
  logic [11:0] rem;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  x8;
  logic [3:0]  root8;
  logic [4:0]  rem8;

  int n_cmp;
  int n_err;

  sqrt_seq #(
    .WIDTH(21)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .root     (root),
    .rem      (rem),
    .busy     (busy)
  );

  sqrt_seq #(
    .WIDTH(8)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .x        (x8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .root     (root8),
    .rem      (rem8),
    .busy     (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic start(input logic [20:0] val);
    x        = val;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int unsigned exp_root,
                             input int unsigned exp_rem, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_root"}, root, exp_root);
    chk({tag, "_rem"}, rem, exp_rem);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [20:0] val,
                     input int unsigned exp_root, input int unsigned exp_rem);
    start(val);
    chk({tag, "_busy"}, busy, 1);
    wait_result(tag, exp_root, exp_rem, 11);
    ack();
    chk({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    int lat8;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    x          = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    x8         = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_root", root, 0);
    chk("rst_rem", rem, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("x0", 21'd0, 0, 0);
    run("x2096704", 21'd2096704, 1448, 0);
    run("x2097151", 21'd2097151, 1448, 447);
    run("x20", 21'd20, 4, 4);
    run("x21", 21'd21, R21, 5);

    // Ignored in_valid during BUSY, then backpressure in DONE.
    start(21'd1000000);
    x        = 21'd4;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_busy", busy, 1);
    wait_result("bp", 1000, 0, 9);
    x        = 21'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_root", root, 1000);
      chk("hold_rem", rem, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hs_in_ready", in_ready, 1);
    chk("hs_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("next_busy", busy, 1);
    wait_result("next", 3, 0, 11);
    ack();

    // Asynchronous reset part way through BUSY.
    start(21'd2096704);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_root", root, 0);
    chk("mid_rem", rem, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run("x144", 21'd144, 12, 0);

    // WIDTH=8: rounding would overflow, so root stays 15 either way.
    x8        = 8'd255;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    lat8      = 0;
    while (!out_valid8 && lat8 < 50) begin
      @(posedge clk);
      #1;
      lat8++;
    end
    chk("w8_lat", lat8, 4);
    chk("w8_root", root8, 15);
    chk("w8_rem", rem8, 30);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    chk("w8_done", out_valid8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
